otter_instr_encoder: RTL

//  - Inverse of the OTTER immediate generator: packs opcode, funct, register and 32-bit immediate

---
 rtl/otter_pkg.sv | 45 ++++
 rtl/otter_instr_pack.sv | 52 +++++
 rtl/otter_instr_encoder.sv | 96 +++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: instruction formats, major opcodes and the field bundle
// handed from the request stage to the instruction packer.
package otter_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instr_fields_t;

  // True when v[31:lsb] are all copies of the sign bit, i.e. v fits in lsb+1 signed bits.
  function automatic logic all_same(input logic [31:0] v, input int lsb);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= lsb && v[i] != v[31]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/otter_instr_pack.sv
// Combinational packer: scatters the immediate back into the RV32I bit positions the
// immediate generator gathers from, and flags immediates the format cannot carry.
module otter_instr_pack
  import otter_pkg::*;
(
  input  instr_fields_t i_fields,
  output logic [31:0]   o_ir,
  output logic          o_err
);

  logic [31:0] w_imm;
  assign w_imm = i_fields.imm;

  always_comb begin
    o_ir  = '0;
    o_err = 1'b0;
    case (i_fields.fmt)
      FMT_R: begin
        o_ir = {i_fields.funct7, i_fields.rs2, i_fields.rs1, i_fields.funct3,
                i_fields.rd, i_fields.opcode};
      end
      FMT_I: begin
        o_ir  = {w_imm[11:0], i_fields.rs1, i_fields.funct3, i_fields.rd, i_fields.opcode};
        o_err = !all_same(w_imm, 11);
      end
      FMT_S: begin
        o_ir  = {w_imm[11:5], i_fields.rs2, i_fields.rs1, i_fields.funct3,
                 w_imm[4:0], i_fields.opcode};
        o_err = !all_same(w_imm, 11);
      end
      FMT_B: begin
        o_ir  = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1, i_fields.funct3,
                 w_imm[4:1], w_imm[11], i_fields.opcode};
        o_err = !all_same(w_imm, 12) || w_imm[0];
      end
      FMT_U: begin
        o_ir  = {w_imm[31:12], i_fields.rd, i_fields.opcode};
        o_err = |w_imm[11:0];
      end
      FMT_J: begin
        o_ir  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_fields.rd, i_fields.opcode};
        o_err = !all_same(w_imm, 20) || w_imm[0];
      end
      // Illegal format codes produce a zero word so nothing executable leaks out.
      default: begin
        o_ir  = '0;
        o_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/otter_instr_encoder.sv
// Two-stage valid/ready wrapper around the instruction packer: S1 holds raw fields,
// S2 holds the packed word, with saturating counts of good and rejected deliveries.
module otter_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  import otter_pkg::*;

  instr_fields_t    r_s1;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [31:0]      r_s2_ir;
  logic             r_s2_err;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_out_fire;
  logic [31:0]      w_pack_ir;
  logic             w_pack_err;

  // Each stage may load when it is empty or its occupant leaves this cycle.
  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign w_out_fire = r_s2_valid && out_ready;

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_ir    = r_s2_ir;
  assign out_err   = r_s2_err;
  assign enc_cnt   = r_enc_cnt;
  assign err_cnt   = r_err_cnt;

  otter_instr_pack u_pack (
    .i_fields (r_s1),
    .o_ir     (w_pack_ir),
    .o_err    (w_pack_err)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                  rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s2_valid <= 1'b0;
      r_s2_ir    <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_ir  <= w_pack_ir;
        r_s2_err <= w_pack_err;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_out_fire) begin
      if (!r_s2_err && r_enc_cnt != {CNT_W{1'b1}}) r_enc_cnt <= r_enc_cnt + 1'b1;
      if (r_s2_err && r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule
